// File: rtl/code_guess_ctrl_pkg.sv
// Shared types and constants for the code-guessing round controller.
// The FSM encoding and the player ids live here so checkers can bind to them.
package code_guess_ctrl_pkg;

    localparam int DEF_N_DIGITS    = 4;
    localparam int DEF_DIGIT_W     = 3;
    localparam int DEF_MAX_GUESSES = 8;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_CODE  = 3'd1,
        ST_WAIT_GUESS = 3'd2,
        ST_SCORE      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    // Selects the button belonging to a given player.
    function automatic logic pick_button(input logic player, input logic btn_a, input logic btn_b);
        return (player == PLAYER_B) ? btn_b : btn_a;
    endfunction

endpackage

// File: rtl/code_guess_ctrl_if.sv
// Player/upstream inputs and score/display outputs of the round controller.
// score_valid is a one-cycle pulse with no ready: exact/partial/guess_cnt change only on it.
interface code_guess_ctrl_if #(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_W     = 3,
    parameter int MAX_GUESSES = 8
);
    logic                                   started;
    logic                                   active_p;
    logic                                   take_code;
    logic                                   enterA;
    logic                                   enterB;
    logic [N_DIGITS*DIGIT_W-1:0]            code_in;
    logic                                   code_locked;
    logic                                   score_valid;
    logic [$clog2(N_DIGITS+1)-1:0]          exact;
    logic [$clog2(N_DIGITS+1)-1:0]          partial;
    logic [$clog2(MAX_GUESSES+1)-1:0]       guess_cnt;
    logic                                   game_over;
    logic                                   winner;

    modport master (
        output started, active_p, take_code, enterA, enterB, code_in,
        input  code_locked, score_valid, exact, partial, guess_cnt, game_over, winner
    );

    modport slave (
        input  started, active_p, take_code, enterA, enterB, code_in,
        output code_locked, score_valid, exact, partial, guess_cnt, game_over, winner
    );
endinterface

// File: rtl/code_guess_ctrl_mm_scorer.sv
// Combinational peg scorer: exact = same colour same slot,
// partial = per-colour overlap of the two codes minus the exact hits.
module mm_scorer #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 3
) (
    input  logic [N_DIGITS*DIGIT_W-1:0]   secret,
    input  logic [N_DIGITS*DIGIT_W-1:0]   guess,
    output logic [$clog2(N_DIGITS+1)-1:0] exact,
    output logic [$clog2(N_DIGITS+1)-1:0] partial
);
    localparam int CW   = $clog2(N_DIGITS + 1);
    localparam int NCOL = 1 << DIGIT_W;

    logic [CW-1:0] cnt_s [NCOL];
    logic [CW-1:0] cnt_g [NCOL];
    logic [CW-1:0] exact_c;
    logic [CW-1:0] match_c;

    always_comb begin
        exact_c = '0;
        match_c = '0;
        for (int c = 0; c < NCOL; c++) begin
            cnt_s[c] = '0;
            cnt_g[c] = '0;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (secret[i*DIGIT_W +: DIGIT_W] == guess[i*DIGIT_W +: DIGIT_W])
                exact_c = exact_c + 1'b1;
            cnt_s[secret[i*DIGIT_W +: DIGIT_W]] = cnt_s[secret[i*DIGIT_W +: DIGIT_W]] + 1'b1;
            cnt_g[guess[i*DIGIT_W +: DIGIT_W]]  = cnt_g[guess[i*DIGIT_W +: DIGIT_W]] + 1'b1;
        end
        // Total colour overlap never exceeds N_DIGITS, so CW bits cannot wrap.
        for (int c = 0; c < NCOL; c++)
            match_c = match_c + ((cnt_s[c] < cnt_g[c]) ? cnt_s[c] : cnt_g[c]);
    end

    assign exact   = exact_c;
    assign partial = match_c - exact_c;

endmodule

// File: rtl/code_guess_ctrl.sv
// Round controller: latches the codemaker's secret, scores codebreaker guesses,
// counts attempts and declares the winner. Outputs are registered.
module code_guess_ctrl
    import code_guess_ctrl_pkg::*;
#(
    parameter int N_DIGITS    = DEF_N_DIGITS,
    parameter int DIGIT_W     = DEF_DIGIT_W,
    parameter int MAX_GUESSES = DEF_MAX_GUESSES
) (
    input  logic             clk,
    input  logic             reset,
    code_guess_ctrl_if.slave bus,
    output state_t           state_dbg
);
    localparam int CODE_W  = N_DIGITS * DIGIT_W;
    localparam int SCORE_W = $clog2(N_DIGITS + 1);
    localparam int CNT_W   = $clog2(MAX_GUESSES + 1);

    state_t              state_q, state_n;
    logic [CODE_W-1:0]   secret_q, secret_n;
    logic [CODE_W-1:0]   guess_q, guess_n;
    logic                locked_q, locked_n;
    logic                valid_q, valid_n;
    logic [SCORE_W-1:0]  exact_q, exact_n;
    logic [SCORE_W-1:0]  partial_q, partial_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic                over_q, over_n;
    logic                winner_q, winner_n;
    logic                prev_a_q, prev_b_q;

    logic                edge_a, edge_b, maker_edge, breaker_edge, round_live;
    logic [SCORE_W-1:0]  sc_exact, sc_partial;

    mm_scorer #(
        .N_DIGITS (N_DIGITS),
        .DIGIT_W  (DIGIT_W)
    ) u_scorer (
        .secret  (secret_q),
        .guess   (guess_q),
        .exact   (sc_exact),
        .partial (sc_partial)
    );

    assign edge_a       = bus.enterA & ~prev_a_q;
    assign edge_b       = bus.enterB & ~prev_b_q;
    assign maker_edge   = pick_button(bus.active_p, edge_a, edge_b);
    assign breaker_edge = pick_button(~bus.active_p, edge_a, edge_b);
    assign round_live   = bus.started & bus.take_code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            secret_q  <= '0;
            guess_q   <= '0;
            locked_q  <= 1'b0;
            valid_q   <= 1'b0;
            exact_q   <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            over_q    <= 1'b0;
            winner_q  <= 1'b0;
            prev_a_q  <= 1'b0;
            prev_b_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            secret_q  <= secret_n;
            guess_q   <= guess_n;
            locked_q  <= locked_n;
            valid_q   <= valid_n;
            exact_q   <= exact_n;
            partial_q <= partial_n;
            cnt_q     <= cnt_n;
            over_q    <= over_n;
            winner_q  <= winner_n;
            prev_a_q  <= bus.enterA;
            prev_b_q  <= bus.enterB;
        end
    end

    always_comb begin
        state_n   = state_q;
        secret_n  = secret_q;
        guess_n   = guess_q;
        locked_n  = locked_q;
        valid_n   = 1'b0;
        exact_n   = exact_q;
        partial_n = partial_q;
        cnt_n     = cnt_q;
        over_n    = over_q;
        winner_n  = winner_q;

        // Losing started/take_code mid-round abandons it as if freshly reset.
        if (state_q != ST_IDLE && !round_live) begin
            state_n   = ST_IDLE;
            secret_n  = '0;
            guess_n   = '0;
            locked_n  = 1'b0;
            exact_n   = '0;
            partial_n = '0;
            cnt_n     = '0;
            over_n    = 1'b0;
            winner_n  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (round_live) state_n = ST_WAIT_CODE;
                end
                ST_WAIT_CODE: begin
                    if (maker_edge) begin
                        secret_n = bus.code_in;
                        locked_n = 1'b1;
                        state_n  = ST_WAIT_GUESS;
                    end
                end
                ST_WAIT_GUESS: begin
                    if (breaker_edge) begin
                        guess_n = bus.code_in;
                        state_n = ST_SCORE;
                    end
                end
                ST_SCORE: begin
                    valid_n   = 1'b1;
                    exact_n   = sc_exact;
                    partial_n = sc_partial;
                    cnt_n     = (cnt_q == CNT_W'(MAX_GUESSES)) ? cnt_q : cnt_q + 1'b1;
                    if (sc_exact == SCORE_W'(N_DIGITS)) begin
                        state_n  = ST_DONE;
                        over_n   = 1'b1;
                        winner_n = ~bus.active_p;
                    end else if (cnt_q == CNT_W'(MAX_GUESSES - 1)) begin
                        state_n  = ST_DONE;
                        over_n   = 1'b1;
                        winner_n = bus.active_p;
                    end else begin
                        state_n = ST_WAIT_GUESS;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.code_locked = locked_q;
    assign bus.score_valid = valid_q;
    assign bus.exact       = exact_q;
    assign bus.partial     = partial_q;
    assign bus.guess_cnt   = cnt_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = winner_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_code_guess_ctrl.sv
// Bench for code_guess_ctrl: a round-level model checked against the DUT every cycle,
// plus directed rounds with hand-computed expectations.
module tb_code_guess_ctrl;
    import code_guess_ctrl_pkg::*;

    localparam int N      = 4;
    localparam int DW     = 3;
    localparam int MAXG   = 8;
    localparam int CODE_W = N * DW;

    logic   clk;
    logic   reset;
    state_t dbg_state;

    code_guess_ctrl_if #(.N_DIGITS(N), .DIGIT_W(DW), .MAX_GUESSES(MAXG)) bus ();

    code_guess_ctrl #(.N_DIGITS(N), .DIGIT_W(DW), .MAX_GUESSES(MAXG)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (dbg_state)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int sv_pulses = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [CODE_W-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
        logic [CODE_W-1:0] c;
        c = '0;
        c[0*DW +: DW] = DW'(d0);
        c[1*DW +: DW] = DW'(d1);
        c[2*DW +: DW] = DW'(d2);
        c[3*DW +: DW] = DW'(d3);
        return c;
    endfunction

    function automatic int digit(input logic [CODE_W-1:0] c, input int i);
        logic [CODE_W-1:0] t;
        t = c >> (i * DW);
        return int'(t[DW-1:0]);
    endfunction

    function automatic int score_exact(input logic [CODE_W-1:0] s, input logic [CODE_W-1:0] g);
        int e;
        e = 0;
        for (int i = 0; i < N; i++)
            if (digit(s, i) == digit(g, i)) e++;
        return e;
    endfunction

    // Greedy pairing of the non-exact slots, one guess peg per secret peg.
    function automatic int score_partial(input logic [CODE_W-1:0] s, input logic [CODE_W-1:0] g);
        bit used [N];
        bit hit  [N];
        bit found;
        int p;
        p = 0;
        for (int i = 0; i < N; i++) begin
            hit[i]  = (digit(s, i) == digit(g, i));
            used[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            found = 1'b0;
            if (!hit[i]) begin
                for (int j = 0; j < N; j++) begin
                    if (!found && !hit[j] && !used[j] && digit(g, j) == digit(s, i)) begin
                        used[j] = 1'b1;
                        found   = 1'b1;
                        p++;
                    end
                end
            end
        end
        return p;
    endfunction

    // ---------------- round model ----------------
    localparam int PH_IDLE = 0, PH_CODE = 1, PH_GUESS = 2, PH_PEND = 3, PH_OVER = 4;

    int                ph        = PH_IDLE;
    logic [CODE_W-1:0] m_secret  = '0;
    logic [CODE_W-1:0] m_guess   = '0;
    logic              m_prev_a  = 1'b0;
    logic              m_prev_b  = 1'b0;
    int                m_locked  = 0;
    int                m_sv      = 0;
    int                m_exact   = 0;
    int                m_partial = 0;
    int                m_cnt     = 0;
    int                m_over    = 0;
    int                m_win     = 0;

    logic ea, eb, mk, br, live;
    assign ea   = bus.enterA && !m_prev_a;
    assign eb   = bus.enterB && !m_prev_b;
    assign mk   = bus.active_p ? eb : ea;
    assign br   = bus.active_p ? ea : eb;
    assign live = bus.started && bus.take_code;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph <= PH_IDLE; m_secret <= '0; m_guess <= '0; m_prev_a <= 1'b0; m_prev_b <= 1'b0;
            m_locked <= 0; m_sv <= 0; m_exact <= 0; m_partial <= 0; m_cnt <= 0; m_over <= 0; m_win <= 0;
        end else begin
            m_prev_a <= bus.enterA;
            m_prev_b <= bus.enterB;
            m_sv     <= 0;
            if (ph != PH_IDLE && !live) begin
                ph <= PH_IDLE; m_secret <= '0; m_guess <= '0;
                m_locked <= 0; m_exact <= 0; m_partial <= 0; m_cnt <= 0; m_over <= 0; m_win <= 0;
            end else if (ph == PH_IDLE) begin
                if (live) ph <= PH_CODE;
            end else if (ph == PH_CODE) begin
                if (mk) begin
                    m_secret <= bus.code_in;
                    m_locked <= 1;
                    ph       <= PH_GUESS;
                end
            end else if (ph == PH_GUESS) begin
                if (br) begin
                    m_guess <= bus.code_in;
                    ph      <= PH_PEND;
                end
            end else if (ph == PH_PEND) begin
                m_sv      <= 1;
                m_exact   <= score_exact(m_secret, m_guess);
                m_partial <= score_partial(m_secret, m_guess);
                m_cnt     <= (m_cnt < MAXG) ? m_cnt + 1 : MAXG;
                if (score_exact(m_secret, m_guess) == N) begin
                    ph <= PH_OVER; m_over <= 1; m_win <= bus.active_p ? 0 : 1;
                end else if (m_cnt + 1 >= MAXG) begin
                    ph <= PH_OVER; m_over <= 1; m_win <= bus.active_p ? 1 : 0;
                end else begin
                    ph <= PH_GUESS;
                end
            end
        end
    end

    // Scoreboard compare on every falling edge outside reset.
    always @(negedge clk) begin
        if (reset) begin
            check("cmp_code_locked", int'(bus.code_locked), m_locked);
            check("cmp_score_valid", int'(bus.score_valid), m_sv);
            check("cmp_exact", int'(bus.exact), m_exact);
            check("cmp_partial", int'(bus.partial), m_partial);
            check("cmp_guess_cnt", int'(bus.guess_cnt), m_cnt);
            check("cmp_game_over", int'(bus.game_over), m_over);
            if (m_over == 1) check("cmp_winner", int'(bus.winner), m_win);
            if (bus.score_valid) sv_pulses++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.started = 1'b0; bus.active_p = 1'b0; bus.take_code = 1'b0;
        bus.enterA = 1'b0; bus.enterB = 1'b0; bus.code_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic start_round(input logic ap);
        bus.active_p = ap; bus.started = 1'b1; bus.take_code = 1'b1;
        tick(2);
    endtask

    task automatic press(input logic on_a, input logic on_b, input logic [CODE_W-1:0] code);
        bus.code_in = code; bus.enterA = on_a; bus.enterB = on_b;
        tick(1);
        bus.enterA = 1'b0; bus.enterB = 1'b0;
        tick(1);
    endtask

    int sv_before;

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1 reset = 1'b0;
        tick(2);
        check("rst_code_locked", int'(bus.code_locked), 0);
        check("rst_score_valid", int'(bus.score_valid), 0);
        check("rst_guess_cnt", int'(bus.guess_cnt), 0);
        check("rst_game_over", int'(bus.game_over), 0);
        check("rst_exact", int'(bus.exact), 0);
        reset = 1'b1;
        tick(1);

        check("pin_exact_1123", score_exact(pack4(1, 1, 2, 3), pack4(1, 2, 1, 5)), 1);
        check("pin_partial_1123", score_partial(pack4(1, 1, 2, 3), pack4(1, 2, 1, 5)), 2);
        check("pin_partial_rev", score_partial(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1)), 4);

        // Maker A latches 0x123; breaker's button in WAIT_CODE is ignored.
        start_round(1'b0);
        press(1'b0, 1'b1, 12'h123);
        check("r1_b_ignored_locked", int'(bus.code_locked), 0);
        bus.code_in = 12'h123; bus.enterA = 1'b1;
        check("r1_locked_before", int'(bus.code_locked), 0);
        tick(1);
        check("r1_locked_next", int'(bus.code_locked), 1);
        bus.enterA = 1'b0;
        tick(1);

        // Breaker B cracks the code first try.
        do_reset();
        start_round(1'b0);
        press(1'b1, 1'b0, pack4(1, 2, 3, 4));
        press(1'b0, 1'b1, pack4(1, 2, 3, 4));
        check("r2_exact", int'(bus.exact), 4);
        check("r2_partial", int'(bus.partial), 0);
        check("r2_game_over", int'(bus.game_over), 1);
        check("r2_winner", int'(bus.winner), 1);
        check("r2_guess_cnt", int'(bus.guess_cnt), 1);
        press(1'b0, 1'b1, pack4(0, 0, 0, 0));
        check("r2_done_cnt_hold", int'(bus.guess_cnt), 1);
        check("r2_done_exact_hold", int'(bus.exact), 4);

        // Mixed score and exact pulse timing.
        do_reset();
        start_round(1'b0);
        press(1'b1, 1'b0, pack4(1, 1, 2, 3));
        sv_before = sv_pulses;
        bus.code_in = pack4(1, 2, 1, 5); bus.enterB = 1'b1;
        tick(1);
        check("r3_sv_t1", int'(bus.score_valid), 0);
        bus.enterB = 1'b0;
        tick(1);
        check("r3_sv_t2", int'(bus.score_valid), 1);
        check("r3_exact", int'(bus.exact), 1);
        check("r3_partial", int'(bus.partial), 2);
        tick(1);
        check("r3_sv_t3", int'(bus.score_valid), 0);
        tick(2);
        check("r3_pulse_count", sv_pulses - sv_before, 1);
        check("r3_exact_hold", int'(bus.exact), 1);

        // Eight misses: codemaker A wins.
        do_reset();
        start_round(1'b0);
        press(1'b1, 1'b0, pack4(7, 7, 7, 7));
        for (int k = 0; k < MAXG; k++) begin
            press(1'b0, 1'b1, pack4(0, 0, 0, 0));
            check("r4_sv", int'(bus.score_valid), 1);
            check("r4_exact", int'(bus.exact), 0);
            check("r4_partial", int'(bus.partial), 0);
        end
        check("r4_game_over", int'(bus.game_over), 1);
        check("r4_winner", int'(bus.winner), 0);
        check("r4_guess_cnt", int'(bus.guess_cnt), 8);
        press(1'b0, 1'b1, pack4(0, 0, 0, 0));
        check("r4_cnt_sat", int'(bus.guess_cnt), 8);

        // Held button scores once; simultaneous A+B scores the breaker's guess.
        do_reset();
        start_round(1'b0);
        press(1'b1, 1'b0, pack4(7, 7, 7, 7));
        sv_before = sv_pulses;
        bus.code_in = pack4(1, 0, 0, 0); bus.enterB = 1'b1;
        tick(20);
        bus.enterB = 1'b0;
        tick(2);
        check("r5_held_pulses", sv_pulses - sv_before, 1);
        check("r5_held_cnt", int'(bus.guess_cnt), 1);
        press(1'b1, 1'b1, pack4(7, 7, 0, 0));
        check("r5_both_cnt", int'(bus.guess_cnt), 2);
        check("r5_both_exact", int'(bus.exact), 2);
        check("r5_both_partial", int'(bus.partial), 0);

        // Maker B: simultaneous edges lock B's code, then A cracks it.
        do_reset();
        start_round(1'b1);
        press(1'b1, 1'b1, pack4(2, 2, 2, 2));
        check("r6_locked", int'(bus.code_locked), 1);
        check("r6_no_score", int'(bus.guess_cnt), 0);
        press(1'b1, 1'b0, pack4(2, 2, 2, 2));
        check("r6_game_over", int'(bus.game_over), 1);
        check("r6_winner", int'(bus.winner), 0);
        check("r6_guess_cnt", int'(bus.guess_cnt), 1);

        // Reset during WAIT_GUESS after three guesses.
        do_reset();
        start_round(1'b0);
        press(1'b1, 1'b0, pack4(1, 2, 3, 4));
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, pack4(4, 3, 2, 1));
        check("r7_cnt3", int'(bus.guess_cnt), 3);
        check("r7_partial4", int'(bus.partial), 4);
        tick(1);
        sv_before = sv_pulses;
        #2 reset = 1'b0;
        #1;
        check("r7_rst_locked", int'(bus.code_locked), 0);
        check("r7_rst_cnt", int'(bus.guess_cnt), 0);
        check("r7_rst_partial", int'(bus.partial), 0);
        check("r7_rst_sv", int'(bus.score_valid), 0);
        check("r7_rst_over", int'(bus.game_over), 0);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("r7_no_pulse", sv_pulses - sv_before, 0);
        check("r7_cnt_after", int'(bus.guess_cnt), 0);

        // Dropping take_code mid-round returns to idle with outputs cleared.
        do_reset();
        start_round(1'b0);
        press(1'b1, 1'b0, pack4(1, 2, 3, 4));
        press(1'b0, 1'b1, pack4(4, 3, 2, 1));
        check("r8_cnt1", int'(bus.guess_cnt), 1);
        bus.take_code = 1'b0;
        tick(1);
        check("r8_drop_cnt", int'(bus.guess_cnt), 0);
        check("r8_drop_locked", int'(bus.code_locked), 0);
        check("r8_drop_partial", int'(bus.partial), 0);
        bus.take_code = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
